// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
// Holds the scan FSM encoding, the dark segment pattern and the digit-bank sizing.
package seg_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Banks are always sized for the widest display so a 2-bit index never overruns.
  localparam int MAX_DIG = 4;

  typedef logic [3:0] digit_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for the scanner: shadow-bank writes, update request and display outputs.
// Update handshake: update is a one-cycle request; upd_busy stays high until the bank is committed at a frame wrap.
interface seg_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic             enable;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [3:0]       wr_data;
  logic             update;
  logic             upd_busy;
  logic [N_DIG-1:0] an;
  logic [7:0]       seg;
  logic [1:0]       dig_idx;
  logic             frame_done;

  modport master (
    output enable, wr_en, wr_addr, wr_data, update,
    input  upd_busy, an, seg, dig_idx, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, update,
    output upd_busy, an, seg, dig_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_dec_seg.sv
// BCD to seven-segment decoder, active-low {a,b,c,d,e,f,g,dp}; values above 9 show an H.
module dec_seg (
  input  logic [3:0] iVal,
  output logic [7:0] oSeg
);
  always_comb begin
    case (iVal)
      4'd0:    oSeg = 8'b00000011;
      4'd1:    oSeg = 8'b10011111;
      4'd2:    oSeg = 8'b00100101;
      4'd3:    oSeg = 8'b00001101;
      4'd4:    oSeg = 8'b10011001;
      4'd5:    oSeg = 8'b01001001;
      4'd6:    oSeg = 8'b01000001;
      4'd7:    oSeg = 8'b00011111;
      4'd8:    oSeg = 8'b00000001;
      4'd9:    oSeg = 8'b00001001;
      default: oSeg = 8'b10010001;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a shadow/active digit bank.
// The shadow bank is copied into the active bank only at a frame wrap, so a frame never tears.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEnable,
  input  logic             iWrEn,
  input  logic [1:0]       iWrAddr,
  input  logic [3:0]       iWrData,
  input  logic             iUpdate,
  output logic             oUpdBusy,
  output logic [N_DIG-1:0] oAn,
  output logic [7:0]       o7seg,
  output logic [1:0]       oDigIdx,
  output logic             oFrameDone
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [1:0]       LAST_IDX   = 2'(N_DIG - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  digit_t           shadow_q [MAX_DIG];
  digit_t           shadow_d [MAX_DIG];
  digit_t           active_q [MAX_DIG];
  digit_t           active_d [MAX_DIG];
  logic             commit;
  logic [7:0]       seg_dec;
  logic [3:0]       an_full;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iEnable) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (!iEnable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == SCAN_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (!iEnable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            commit       = pending_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // A request arriving on the commit edge outranks the clear, so it is held for the next wrap.
  always_comb begin
    pending_d = pending_q;
    if (commit)  pending_d = 1'b0;
    if (iUpdate) pending_d = 1'b1;
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (commit) active_d = shadow_q;
    if (iWrEn && (int'(iWrAddr) < N_DIG)) shadow_d[iWrAddr] = iWrData;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < MAX_DIG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  dec_seg u_dec_seg (
    .iVal (active_q[idx_q]),
    .oSeg (seg_dec)
  );

  assign an_full    = ~(4'b0001 << idx_q);
  assign oAn        = (state_q == ST_SCAN) ? an_full[N_DIG-1:0] : '1;
  assign o7seg      = (state_q == ST_SCAN) ? seg_dec : SEG_BLANK;
  assign oDigIdx    = idx_q;
  assign oUpdBusy   = pending_q;
  assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model feeds an expected queue,
// a negedge monitor pops and compares every cycle.
module tb_seg_scan_ctrl;
  localparam int N_DIG     = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = SCAN_DIV + BLANK_CYC;
  localparam int FRAME     = N_DIG * SLOT;
  localparam int W         = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [W-1:0] exp_q[$];

  seg_scan_ctrl_if #(.N_DIG(N_DIG)) bus ();

  seg_scan_ctrl #(.N_DIG(N_DIG), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iEnable    (bus.enable),
    .iWrEn      (bus.wr_en),
    .iWrAddr    (bus.wr_addr),
    .iWrData    (bus.wr_data),
    .iUpdate    (bus.update),
    .oUpdBusy   (bus.upd_busy),
    .oAn        (bus.an),
    .o7seg      (bus.seg),
    .oDigIdx    (bus.dig_idx),
    .oFrameDone (bus.frame_done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 8'b00000011;
      4'd1: return 8'b10011111;
      4'd2: return 8'b00100101;
      4'd3: return 8'b00001101;
      4'd4: return 8'b10011001;
      4'd5: return 8'b01001001;
      4'd6: return 8'b01000001;
      4'd7: return 8'b00011111;
      4'd8: return 8'b00000001;
      4'd9: return 8'b00001001;
      default: return 8'b10010001;
    endcase
  endfunction

  // reference model: position within the frame plus the two digit banks
  bit         running   = 0;
  int         t         = 0;
  logic [3:0] m_shadow [N_DIG];
  logic [3:0] m_active [N_DIG];
  bit         m_pending = 0;
  bit         m_fd      = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      running = 0; t = 0; m_pending = 0; m_fd = 0;
      for (int i = 0; i < N_DIG; i++) begin
        m_shadow[i] = 4'd0;
        m_active[i] = 4'd0;
      end
      exp_q.delete();
    end else begin
      bit         commit;
      logic [3:0] an;
      logic [7:0] seg;
      logic [1:0] idx;
      int         d;
      commit = 0;
      m_fd   = 0;
      if (!running) begin
        if (bus.enable) begin running = 1; t = 0; end
      end else if (!bus.enable) begin
        running = 0;
      end else if (t == FRAME - 1) begin
        t = 0; m_fd = 1; commit = m_pending;
      end else begin
        t++;
      end
      if (commit) begin
        for (int i = 0; i < N_DIG; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end
      if (bus.wr_en && int'(bus.wr_addr) < N_DIG) m_shadow[bus.wr_addr] = bus.wr_data;
      if (bus.update) m_pending = 1;
      an = 4'hF; seg = 8'hFF; idx = 2'd0;
      if (running) begin
        d   = t / SLOT;
        idx = 2'(d);
        if ((t % SLOT) < SCAN_DIV) begin
          an     = 4'hF;
          an[d]  = 1'b0;
          seg    = seg_of(m_active[d]);
        end
      end
      exp_q.push_back({an, seg, idx, m_fd, m_pending});
    end
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_an",   bus.an,         4'hF);
      check("rst_seg",  bus.seg,        8'hFF);
      check("rst_idx",  bus.dig_idx,    2'd0);
      check("rst_fd",   bus.frame_done, 1'b0);
      check("rst_busy", bus.upd_busy,   1'b0);
    end else if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("an",         bus.an,         e[15:12]);
      check("seg",        bus.seg,        e[11:4]);
      check("dig_idx",    bus.dig_idx,    e[3:2]);
      check("frame_done", bus.frame_done, e[1]);
      check("upd_busy",   bus.upd_busy,   e[0]);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] dat);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = dat;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_upd();
    bus.update = 1'b1;
    step();
    bus.update = 1'b0;
  endtask

  task automatic wait_fd(input int bound);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.frame_done && k < bound);
    check("frame_done_seen", bus.frame_done, 1'b1);
  endtask

  task automatic finish_report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    finish_report();
  end

  initial begin
    int c0;
    bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = 2'd0;
    bus.wr_data = 4'd0; bus.update = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // load 1..4 while dark, request update, start scanning
    wr(2'd0, 4'd1); wr(2'd1, 4'd2); wr(2'd2, 4'd3); wr(2'd3, 4'd4);
    pulse_upd();
    check("busy_pending", bus.upd_busy, 1'b1);
    bus.enable = 1'b1;
    wait_fd(60);
    c0 = cyc;
    wait_fd(60);
    check("frame_period", 32'(cyc - c0), 32'(FRAME));

    // update request landing in the commit cycle, plus a write in the same cycle
    wr(2'd0, 4'd5); wr(2'd1, 4'd6); wr(2'd2, 4'd7); wr(2'd3, 4'd8);
    pulse_upd();
    repeat (FRAME - 1 - 5) step();
    bus.update = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 4'd9;
    step();
    bus.update = 1'b0; bus.wr_en = 1'b0;
    check("wrap_after_commit_upd", bus.frame_done, 1'b1);
    check("busy_after_commit_upd", bus.upd_busy, 1'b1);
    wait_fd(60);
    check("busy_cleared", bus.upd_busy, 1'b0);

    // enable dropped at cnt=2 of digit 2
    pulse_upd();
    repeat (2 * SLOT + 2 - 1) step();
    bus.enable = 1'b0;
    step();
    check("drop_an",   bus.an,       4'hF);
    check("drop_idx",  bus.dig_idx,  2'd0);
    check("drop_busy", bus.upd_busy, 1'b1);
    repeat (5) step();
    bus.enable = 1'b1;
    wait_fd(60);

    // value 12 on digit 1
    wr(2'd1, 4'hC);
    pulse_upd();
    wait_fd(60);
    repeat (SLOT) step();
    check("hex_c_an",  bus.an,  4'b1101);
    check("hex_c_seg", bus.seg, 8'b10010001);

    // randomized traffic
    repeat (500) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 2'($urandom_range(0, 3));
      bus.wr_data = 4'($urandom_range(0, 15));
      bus.update  = ($urandom_range(0, 19) == 0);
      bus.enable  = ($urandom_range(0, 59) != 0);
      step();
    end
    bus.wr_en = 1'b0; bus.update = 1'b0; bus.enable = 1'b1;
    wait_fd(60);

    // reset mid-blank with a commit pending
    wr(2'd0, 4'd7); wr(2'd1, 4'd7); wr(2'd2, 4'd7); wr(2'd3, 4'd7);
    pulse_upd();
    rst = 1'b1;
    #1;
    check("async_an",   bus.an,         4'hF);
    check("async_seg",  bus.seg,        8'hFF);
    check("async_idx",  bus.dig_idx,    2'd0);
    check("async_busy", bus.upd_busy,   1'b0);
    check("async_fd",   bus.frame_done, 1'b0);
    step(); step();
    rst = 1'b0;
    wr(2'd2, 4'd3);
    wait_fd(60);
    wait_fd(60);
    check("no_commit_busy", bus.upd_busy, 1'b0);
    repeat (3) step();
    finish_report();
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 4; number of multiplexed digits (2..4).
REQ-002 SHALL have parameter SCAN_DIV, default 50000; clock cycles each digit is lit.
REQ-003 SHALL have parameter BLANK_CYC, default 16; cycles all anodes are off between digits (anti-ghosting).
REQ-004 SHALL have port iClk, input, 1; the single clock, all state on rising edge.
REQ-005 SHALL have port iRst, input, 1; reset, asynchronous, active-high.
REQ-006 SHALL have port iEnable, input, 1; 1 = scan, 0 = display dark.
REQ-007 SHALL have port iWrEn, input, 1; write strobe into the shadow digit bank.
REQ-008 SHALL have port iWrAddr, input, 2; shadow digit index; writes with iWrAddr >= N_DIG are ignored.
REQ-009 SHALL have port iWrData, input, 4; digit value, BCD 0-9; 10-15 are passed through.
REQ-010 SHALL have port iUpdate, input, 1; one-cycle request to copy the shadow bank to the active bank.
REQ-011 SHALL have port oUpdBusy, output, 1; 1 while an update request is pending.
REQ-012 SHALL have port oAn, output, N_DIG; anode enables, active-low, one-hot-low or all ones.
REQ-013 SHALL have port o7seg, output, 8; segments {a..g,dp}, active-low, from DEC_SEG.
REQ-014 SHALL have port oDigIdx, output, 2; index of the digit currently scanned.
REQ-015 SHALL have port oFrameDone, output, 1; one-cycle pulse at each frame wrap.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN and BLANK, with one cycle counter and one digit index idx.
REQ-017 IDLE with iEnable=1 SHALL enter SCAN on the next edge with idx=0 and cnt=0.
REQ-018 SCAN SHALL last exactly SCAN_DIV cycles (cnt 0..SCAN_DIV-1), then go to BLANK with cnt=0.
REQ-019 BLANK SHALL last exactly BLANK_CYC cycles, then go to SCAN with idx+1 and cnt=0.
REQ-020 When idx=N_DIG-1, the BLANK exit SHALL wrap idx to 0, pulse oFrameDone for 1 cycle and perform the commit of REQ-024.
REQ-021 In SCAN, oAn bit idx SHALL be 0 and all others 1; o7seg SHALL be DEC_SEG(active[idx]).
REQ-022 In IDLE and BLANK, oAn SHALL be all ones and o7seg SHALL be 8'hFF.
REQ-023 iWrEn SHALL write iWrData into shadow[iWrAddr] on the same edge in any state, including IDLE.
REQ-024 Commit SHALL copy all shadow entries to the active bank in one edge, only at a frame wrap while pending=1, and SHALL clear pending.
REQ-025 iUpdate SHALL set pending, which drives oUpdBusy; iUpdate while pending=1 has no additional effect.
REQ-026 iUpdate in the commit cycle SHALL leave pending=1, so the request is not lost.
REQ-027 iWrEn in the commit cycle SHALL update shadow, while active receives the pre-write shadow value.
REQ-028 iEnable=0 in SCAN or BLANK SHALL force IDLE on the next edge with idx=0 and cnt=0; shadow, active and pending are retained.
REQ-029 oAn, o7seg and oDigIdx SHALL depend only on registered state, idx and active registers; there is no combinational path from any input.
REQ-030 Values 10-15 SHALL be displayed as DEC_SEG's default pattern 8'b10010001.

Reset
REQ-031 iRst SHALL asynchronously force state=IDLE, idx=0, cnt=0 and pending=0.
REQ-032 iRst SHALL asynchronously clear all shadow and active entries to 0.
REQ-033 During iRst, outputs SHALL be oAn=all ones, o7seg=8'hFF, oDigIdx=0, oUpdBusy=0 and oFrameDone=0.
REQ-034 Reset asserted mid-frame SHALL discard any pending commit.

Structure
REQ-035 A shared package SHALL hold the state encoding and the blank pattern constant 8'hFF.
REQ-036 SHALL instantiate exactly one DEC_SEG, fed by active[idx]; there are no other sub-modules.

Verification (SCAN_DIV=4, BLANK_CYC=2, N_DIG=4)
REQ-037 Reset, write shadow={1,2,3,4}, iUpdate, iEnable=1 -> first frame shows 0 on all digits (oAn 1110, 1101, 1011, 0111, each for 4 cycles, with 2 dark cycles between). -> oFrameDone pulses at wrap. -> Second frame shows o7seg 10011111, 00100101, 00001101, 10011001.
REQ-038 Frame period SHALL measure 24 cycles, with oFrameDone pulses exactly 24 cycles apart.
REQ-039 iUpdate asserted in the commit cycle -> oUpdBusy stays 1 -> commit repeats at the next wrap.
REQ-040 iEnable dropped at cnt=2 of digit 2 -> next cycle oAn=1111 and oDigIdx=0. -> Re-enable restarts at digit 0 with pending preserved.
REQ-041 Write 4'hC to digit 1 and commit -> digit 1 shows 10010001.
REQ-042 iRst pulsed mid-BLANK with pending=1 -> outputs reach reset values without a clock edge. -> oUpdBusy=0, and no commit occurs afterwards.
